run_detect_sched: RTL

Time-multiplexed controller that shares one consecutive-ones run-length counter datapath among NUM_CH serial bit requesters. A round-robin arbiter grants one channel per cycle and restores that channel's saved run count. The shared core updates the count and writes it back. A detect event (channel id and count) is emitted when a run first exceeds the programmable threshold. The block sits between the serial bit sources and the event-logging logic.

---
 rtl/run_detect_pkg.sv | 30 +++
 rtl/run_detect_sched_if.sv | 36 +++
 rtl/run_count_core.sv | 38 +++
 rtl/run_detect_sched.sv | 118 +++++++++++
 4 files changed

// File: rtl/run_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_pkg
// Purpose  : Shared types, width limits and the saturating-increment helper
//            for the run_detect_sched time-multiplexed run detector.
// Revision : 1.0 - initial release
// ============================================================================
package run_detect_pkg;

  // Default run-count width; channel count is bounded at 16, counts at 16 bits
  localparam int CNT_W_DEF = 4;
  localparam int CNT_W_MAX = 16;
  localparam int CH_W_MAX  = 4;

  // Detect event record, sized for the largest supported configuration
  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [CNT_W_MAX-1:0] count;
  } det_evt_t;

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [CNT_W_MAX-1:0] sat_inc(
    input logic [CNT_W_MAX-1:0] v,
    input logic [CNT_W_MAX-1:0] max_v
  );
    return (v >= max_v) ? max_v : (v + CNT_W_MAX'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_detect_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_sched_if
// Purpose  : Requester / event-consumer bundle for run_detect_sched. The
//            master side drives requests and accepts events; the slave side
//            is the scheduler itself.
// Revision : 1.0 - initial release
// ============================================================================
interface run_detect_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = run_detect_pkg::CNT_W_DEF
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [CNT_W-1:0]  threshold;
  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_data;
  logic [NUM_CH-1:0] req_ready;
  logic              det_valid;
  logic [CH_W-1:0]   det_ch;
  logic [CNT_W-1:0]  det_count;
  logic              det_ready;
  logic [NUM_CH-1:0] run_active;

  modport master (
    output threshold, req_valid, req_data, det_ready,
    input  req_ready, det_valid, det_ch, det_count, run_active
  );

  modport slave (
    input  threshold, req_valid, req_data, det_ready,
    output req_ready, det_valid, det_ch, det_count, run_active
  );

endinterface
`default_nettype wire

// File: rtl/run_count_core.sv
`default_nettype none
// ============================================================================
// Module   : run_count_core
// Purpose  : Shared run-length datapath. Given the restored count of the
//            granted channel and its new bit, produce the updated count and
//            flag the first crossing above the threshold.
// Revision : 1.0 - initial release
// ============================================================================
module run_count_core
  import run_detect_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] old_i,
  input  logic             bit_i,
  input  logic [CNT_W-1:0] threshold_i,
  output logic [CNT_W-1:0] new_o,
  output logic             fire_o
);

  localparam logic [CNT_W_MAX-1:0] C_CNT_MAX = CNT_W_MAX'((1 << CNT_W) - 1);

  logic [CNT_W_MAX-1:0] w_inc;
  logic                 w_inc_hi_unused;

  // The helper works at the package's maximum width; only the low CNT_W
  // bits carry the result because the saturation point fits in CNT_W.
  assign w_inc           = sat_inc(CNT_W_MAX'(old_i), C_CNT_MAX);
  assign w_inc_hi_unused = ^w_inc;

  // A zero bit ends the run; a one bit extends it
  assign new_o  = bit_i ? w_inc[CNT_W-1:0] : '0;

  // Fire only on the crossing, so a run produces at most one event
  assign fire_o = (old_i <= threshold_i) && (new_o > threshold_i);

endmodule
`default_nettype wire

// File: rtl/run_detect_sched.sv
`default_nettype none
// ============================================================================
// Module   : run_detect_sched
// Purpose  : Round-robin scheduler sharing one run counter among NUM_CH
//            serial requesters, with per-channel saved context and a single
//            registered detect-event output.
// Revision : 1.0 - initial release
// ============================================================================
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  run_detect_sched_if.slave  bus
);

  localparam int              CH_W       = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] C_LAST_RST = CH_W'(NUM_CH - 1);

  logic [CNT_W-1:0]  r_ctx_q [NUM_CH];
  logic [CH_W-1:0]   r_last_q;
  logic              r_det_valid_q;
  det_evt_t          r_evt_q;
  det_evt_t          w_evt_d;
  logic              w_evt_unused;

  logic              w_stall;
  logic              w_found;
  logic              w_xfer;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CNT_W-1:0]  w_old;
  logic [CNT_W-1:0]  w_new;
  logic              w_bit;
  logic              w_fire;

  // A pending event the consumer is not taking blocks all new grants
  assign w_stall = r_det_valid_q & ~bus.det_ready;

  // Round-robin search starting one past the last granted channel
  always_comb begin
    int              idx;
    logic [CH_W-1:0] idx_c;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    idx_c     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx   = (int'(r_last_q) + k) % NUM_CH;
      idx_c = CH_W'(idx);
      if (!w_found && bus.req_valid[idx_c]) begin
        w_found   = 1'b1;
        w_gnt_idx = idx_c;
      end
    end
  end

  assign w_xfer        = w_found & ~w_stall;
  assign bus.req_ready = w_xfer ? (NUM_CH'(1) << w_gnt_idx) : '0;

  // Restore the granted channel's context into the shared core
  assign w_old = r_ctx_q[w_gnt_idx];
  assign w_bit = bus.req_data[w_gnt_idx];

  run_count_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .old_i       (w_old),
    .bit_i       (w_bit),
    .threshold_i (bus.threshold),
    .new_o       (w_new),
    .fire_o      (w_fire)
  );

  assign w_evt_d.ch    = CH_W_MAX'(w_gnt_idx);
  assign w_evt_d.count = CNT_W_MAX'(w_new);

  assign bus.det_valid = r_det_valid_q;
  assign bus.det_ch    = r_evt_q.ch[CH_W-1:0];
  assign bus.det_count = r_evt_q.count[CNT_W-1:0];
  // Upper struct bits exist only for wider configurations
  assign w_evt_unused  = ^r_evt_q;

  // Run-active level per channel tracks the live threshold
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_run_active
      assign bus.run_active[i] = (r_ctx_q[i] > bus.threshold);
    end
  endgenerate

  // Context write-back, arbiter pointer and the single-entry event register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ctx_q[i] <= '0;
      end
      r_last_q      <= C_LAST_RST;
      r_det_valid_q <= 1'b0;
      r_evt_q       <= '0;
    end else begin
      if (w_xfer) begin
        r_ctx_q[w_gnt_idx] <= w_new;
        r_last_q           <= w_gnt_idx;
      end
      // A new event may replace one being accepted this cycle without a gap
      if (w_xfer && w_fire) begin
        r_det_valid_q <= 1'b1;
        r_evt_q       <= w_evt_d;
      end else if (r_det_valid_q && bus.det_ready) begin
        r_det_valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
